// File: rtl/frame_gen_pkg.sv
// Shared constants and types for the parametrised TX frame generator.
// K characters, payload-source and FSM enums, and the legacy fixed byte pattern.
package frame_gen_pkg;

  localparam logic [7:0] K28_5 = 8'hBC;
  localparam logic [7:0] K27_7 = 8'hFB;
  localparam logic [7:0] K29_7 = 8'hFD;

  typedef enum logic [1:0] {
    FIXED   = 2'd0,
    COUNTER = 2'd1,
    PRBS7   = 2'd2,
    STREAM  = 2'd3
  } mode_t;

  typedef enum logic [1:0] {
    GAP     = 2'd0,
    SOF     = 2'd1,
    PAYLOAD = 2'd2,
    EOF     = 2'd3
  } state_t;

  // Byte i of the legacy pattern lives in bits [8*i +: 8].
  localparam int          FIX_LEN     = 6;
  localparam logic [47:0] FIX_PATTERN = 48'h23_A7_40_34_58_54;

  function automatic logic [7:0] fix_byte(input int idx);
    logic [47:0] pat;
    pat = FIX_PATTERN;
    return pat[(idx % FIX_LEN) * 8 +: 8];
  endfunction

endpackage

// File: rtl/prbs7_par.sv
// Parallel PRBS7 (x^7 + x^6 + 1) generator, W bits per enabled cycle, LSB first.
// The word reflects the current LFSR state; the state advances W steps when en is high.
module prbs7_par #(
  parameter int W = 16
) (
  input  logic         aclk,
  input  logic         aresetn,
  input  logic         en,
  output logic [W-1:0] word
);

  logic [6:0] lfsr_q, lfsr_d;

  always_comb begin
    lfsr_d = lfsr_q;
    word   = '0;
    for (int i = 0; i < W; i++) begin
      word[i] = lfsr_d[6] ^ lfsr_d[5];
      lfsr_d  = {lfsr_d[5:0], word[i]};
    end
  end

  always_ff @(posedge aclk) begin
    if (!aresetn) begin
      lfsr_q <= 7'h7F;
    end else if (en) begin
      lfsr_q <= lfsr_d;
    end
  end

endmodule

// File: rtl/frame_gen_mc.sv
// Framed 8b/10b-ready word generator for the GTP TX path: comma gap, SOF+seq,
// payload from a selectable source, EOF+XOR checksum. Outputs are registered.
module frame_gen_mc
  import frame_gen_pkg::*;
#(
  parameter int BYTES         = 2,
  parameter int PAYLOAD_WORDS = 6,
  parameter int GAP_WORDS     = 4
) (
  input  logic               aclk,
  input  logic               aresetn,
  input  logic               link_ready,
  input  logic [1:0]         mode,
  input  logic [8*BYTES-1:0] s_data,
  input  logic               s_valid,
  output logic               s_ready,
  output logic [8*BYTES-1:0] tx_data,
  output logic [BYTES-1:0]   tx_charisk,
  output logic [7:0]         seq,
  output logic               underrun
);

  localparam int         W        = 8 * BYTES;
  localparam logic [7:0] GAP_LAST = 8'(GAP_WORDS - 1);
  localparam logic [7:0] PAY_LAST = 8'(PAYLOAD_WORDS - 1);

  state_t           state_q, state_d;
  mode_t            mode_q, mode_d;
  logic [7:0]       gap_cnt_q, gap_cnt_d;
  logic [7:0]       word_cnt_q, word_cnt_d;
  logic [7:0]       seq_q, seq_d;
  logic [7:0]       csum_q, csum_d;
  logic [2:0]       fix_idx_q, fix_idx_d;
  logic [W-1:0]     tx_data_q, tx_data_d;
  logic [BYTES-1:0] tx_charisk_q, tx_charisk_d;
  logic             underrun_q, underrun_d;

  logic [W-1:0] fix_word, cnt_word, prbs_word, pay_word;
  logic [7:0]   pay_xor;
  logic         prbs_en;

  prbs7_par #(.W(W)) u_prbs (
    .aclk    (aclk),
    .aresetn (aresetn),
    .en      (prbs_en),
    .word    (prbs_word)
  );

  // Per-lane payload bytes for the two arithmetic sources.
  for (genvar gi = 0; gi < BYTES; gi++) begin : g_lane
    assign fix_word[gi*8 +: 8] = fix_byte(int'(fix_idx_q) + gi);
    assign cnt_word[gi*8 +: 8] = 8'(int'(word_cnt_q) * BYTES + gi);
  end

  always_comb begin
    pay_word = '0;
    case (mode_q)
      FIXED:   pay_word = fix_word;
      COUNTER: pay_word = cnt_word;
      PRBS7:   pay_word = prbs_word;
      STREAM:  pay_word = s_valid ? s_data : '0;
    endcase
    pay_xor = 8'h00;
    for (int b = 0; b < BYTES; b++) begin
      pay_xor = pay_xor ^ pay_word[b*8 +: 8];
    end
  end

  assign s_ready = aresetn && link_ready && (state_q == PAYLOAD) && (mode_q == STREAM);

  always_comb begin
    state_d      = state_q;
    mode_d       = mode_q;
    gap_cnt_d    = gap_cnt_q;
    word_cnt_d   = word_cnt_q;
    seq_d        = seq_q;
    csum_d       = csum_q;
    fix_idx_d    = fix_idx_q;
    tx_data_d    = '0;
    tx_charisk_d = '0;
    underrun_d   = 1'b0;
    prbs_en      = 1'b0;

    // Link loss aborts the frame silently; seq, PRBS and pattern position survive.
    if (!link_ready) begin
      state_d    = GAP;
      gap_cnt_d  = 8'd0;
      word_cnt_d = 8'd0;
    end else begin
      case (state_q)
        GAP: begin
          tx_data_d    = {BYTES{K28_5}};
          tx_charisk_d = '1;
          if (gap_cnt_q == GAP_LAST) begin
            gap_cnt_d = 8'd0;
            mode_d    = mode_t'(mode);
            state_d   = SOF;
          end else begin
            gap_cnt_d = gap_cnt_q + 8'd1;
          end
        end
        SOF: begin
          tx_data_d[7:0]  = K27_7;
          tx_data_d[15:8] = seq_q;
          tx_charisk_d[0] = 1'b1;
          csum_d          = 8'h00;
          seq_d           = seq_q + 8'd1;
          word_cnt_d      = 8'd0;
          state_d         = PAYLOAD;
        end
        PAYLOAD: begin
          tx_data_d  = pay_word;
          csum_d     = csum_q ^ pay_xor;
          underrun_d = (mode_q == STREAM) && !s_valid;
          prbs_en    = (mode_q == PRBS7);
          if (mode_q == FIXED) begin
            fix_idx_d = 3'((int'(fix_idx_q) + BYTES) % FIX_LEN);
          end
          if (word_cnt_q == PAY_LAST) begin
            word_cnt_d = 8'd0;
            state_d    = EOF;
          end else begin
            word_cnt_d = word_cnt_q + 8'd1;
          end
        end
        EOF: begin
          tx_data_d[7:0]  = K29_7;
          tx_data_d[15:8] = csum_q;
          tx_charisk_d[0] = 1'b1;
          state_d         = GAP;
        end
      endcase
    end
  end

  always_ff @(posedge aclk) begin
    if (!aresetn) begin
      state_q      <= GAP;
      mode_q       <= FIXED;
      gap_cnt_q    <= 8'd0;
      word_cnt_q   <= 8'd0;
      seq_q        <= 8'd0;
      csum_q       <= 8'd0;
      fix_idx_q    <= 3'd0;
      tx_data_q    <= '0;
      tx_charisk_q <= '0;
      underrun_q   <= 1'b0;
    end else begin
      state_q      <= state_d;
      mode_q       <= mode_d;
      gap_cnt_q    <= gap_cnt_d;
      word_cnt_q   <= word_cnt_d;
      seq_q        <= seq_d;
      csum_q       <= csum_d;
      fix_idx_q    <= fix_idx_d;
      tx_data_q    <= tx_data_d;
      tx_charisk_q <= tx_charisk_d;
      underrun_q   <= underrun_d;
    end
  end

  assign tx_data    = tx_data_q;
  assign tx_charisk = tx_charisk_q;
  assign seq        = seq_q;
  assign underrun   = underrun_q;

endmodule

// File: tb/tb_frame_gen_mc.sv
// Directed bench for frame_gen_mc: a 2-byte and a 4-byte instance share the
// control inputs; expected words are hand-computed constants.
module tb_frame_gen_mc;
  import frame_gen_pkg::*;

  logic        aclk = 1'b0;
  logic        aresetn;
  logic        link_ready;
  logic [1:0]  mode;
  logic [15:0] s_data;
  logic [31:0] s_data4;
  logic        s_valid;

  logic        s_ready2, underrun2;
  logic [15:0] tx_data2;
  logic [1:0]  tx_k2;
  logic [7:0]  seq2;
  logic        s_ready4, underrun4;
  logic [31:0] tx_data4;
  logic [3:0]  tx_k4;
  logic [7:0]  seq4;

  int n_vec = 0;
  int n_err = 0;

  always #5 aclk = ~aclk;

  frame_gen_mc #(.BYTES(2), .PAYLOAD_WORDS(3), .GAP_WORDS(2)) dut2 (
    .aclk       (aclk),
    .aresetn    (aresetn),
    .link_ready (link_ready),
    .mode       (mode),
    .s_data     (s_data),
    .s_valid    (s_valid),
    .s_ready    (s_ready2),
    .tx_data    (tx_data2),
    .tx_charisk (tx_k2),
    .seq        (seq2),
    .underrun   (underrun2)
  );

  frame_gen_mc #(.BYTES(4), .PAYLOAD_WORDS(1), .GAP_WORDS(2)) dut4 (
    .aclk       (aclk),
    .aresetn    (aresetn),
    .link_ready (link_ready),
    .mode       (mode),
    .s_data     (s_data4),
    .s_valid    (s_valid),
    .s_ready    (s_ready4),
    .tx_data    (tx_data4),
    .tx_charisk (tx_k4),
    .seq        (seq4),
    .underrun   (underrun4)
  );

  task automatic check_vec(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, expected %0h", tag, obs, exp);
    end else begin
      $display("ok   %s: %0h", tag, obs);
    end
  endtask

  task automatic step();
    @(posedge aclk);
    #1;
  endtask

  task automatic hold_reset(input logic [1:0] m);
    aresetn    = 1'b0;
    link_ready = 1'b1;
    s_valid    = 1'b0;
    s_data     = 16'h0000;
    mode       = m;
    step();
    step();
    aresetn = 1'b1;
  endtask

  logic [15:0] cnt_d2  [10] = '{16'hBCBC, 16'hBCBC, 16'h00FB, 16'h0100, 16'h0302,
                                16'h0504, 16'h01FD, 16'hBCBC, 16'hBCBC, 16'h01FB};
  logic [1:0]  cnt_k2  [10] = '{2'b11, 2'b11, 2'b01, 2'b00, 2'b00,
                                2'b00, 2'b01, 2'b11, 2'b11, 2'b01};
  logic [31:0] cnt_d4  [10] = '{32'hBCBCBCBC, 32'hBCBCBCBC, 32'h000000FB, 32'h03020100, 32'h000000FD,
                                32'hBCBCBCBC, 32'hBCBCBCBC, 32'h000001FB, 32'h03020100, 32'h000000FD};
  logic [3:0]  cnt_k4  [10] = '{4'hF, 4'hF, 4'h1, 4'h0, 4'h1, 4'hF, 4'hF, 4'h1, 4'h0, 4'h1};
  logic [15:0] fix_d2  [11] = '{16'hBCBC, 16'hBCBC, 16'h00FB, 16'h5854, 16'h4034, 16'h23A7,
                                16'hFCFD, 16'hBCBC, 16'hBCBC, 16'h01FB, 16'h5854};
  logic [31:0] fix_d4  [11] = '{32'hBCBCBCBC, 32'hBCBCBCBC, 32'h000000FB, 32'h40345854, 32'h000078FD,
                                32'hBCBCBCBC, 32'hBCBCBCBC, 32'h000001FB, 32'h585423A7, 32'h000088FD,
                                32'hBCBCBCBC};

  initial begin
    int rdy_cnt;
    int ur_cnt;
    s_data4 = 32'h0;

    // Reset state, then COUNTER frames on both widths.
    hold_reset(COUNTER);
    check_vec("rst_tx", 64'(tx_data2), 64'h0);
    check_vec("rst_k", 64'(tx_k2), 64'h0);
    check_vec("rst_seq", 64'(seq2), 64'h0);
    check_vec("rst_rdy", 64'(s_ready2), 64'h0);
    check_vec("rst_ur", 64'(underrun2), 64'h0);
    check_vec("rst_tx4", 64'(tx_data4), 64'h0);
    for (int i = 0; i < 10; i++) begin
      step();
      check_vec($sformatf("cnt2_d[%0d]", i), 64'(tx_data2), 64'(cnt_d2[i]));
      check_vec($sformatf("cnt2_k[%0d]", i), 64'(tx_k2), 64'(cnt_k2[i]));
      check_vec($sformatf("cnt4_d[%0d]", i), 64'(tx_data4), 64'(cnt_d4[i]));
      check_vec($sformatf("cnt4_k[%0d]", i), 64'(tx_k4), 64'(cnt_k4[i]));
    end
    check_vec("cnt2_seq", 64'(seq2), 64'd2);
    check_vec("cnt4_seq", 64'(seq4), 64'd2);

    // Reset in the middle of a frame clears everything.
    aresetn = 1'b0;
    step();
    check_vec("midrst_tx", 64'(tx_data2), 64'h0);
    check_vec("midrst_seq", 64'(seq2), 64'h0);

    // FIXED pattern, continuity across frames.
    hold_reset(FIXED);
    for (int i = 0; i < 11; i++) begin
      step();
      check_vec($sformatf("fix2_d[%0d]", i), 64'(tx_data2), 64'(fix_d2[i]));
      check_vec($sformatf("fix4_d[%0d]", i), 64'(tx_data4), 64'(fix_d4[i]));
    end

    // STREAM with one missing word.
    hold_reset(STREAM);
    s_valid = 1'b1;
    s_data  = 16'hA1B2;
    rdy_cnt = 0;
    ur_cnt  = 0;
    for (int i = 1; i <= 9; i++) begin
      step();
      rdy_cnt += int'(s_ready2);
      ur_cnt  += int'(underrun2);
      case (i)
        2: check_vec("str_rdy_gap", 64'(s_ready2), 64'h0);
        3: begin
          check_vec("str_sof", 64'(tx_data2), 64'h00FB);
          check_vec("str_rdy_pay", 64'(s_ready2), 64'h1);
        end
        4: begin
          check_vec("str_w0", 64'(tx_data2), 64'hA1B2);
          check_vec("str_ur0", 64'(underrun2), 64'h0);
          s_valid = 1'b0;
        end
        5: begin
          check_vec("str_w1", 64'(tx_data2), 64'h0000);
          check_vec("str_ur1", 64'(underrun2), 64'h1);
          s_valid = 1'b1;
          s_data  = 16'hC3D4;
        end
        6: begin
          check_vec("str_w2", 64'(tx_data2), 64'hC3D4);
          check_vec("str_rdy_eof", 64'(s_ready2), 64'h0);
        end
        7: check_vec("str_eof", 64'(tx_data2), 64'h04FD);
        8: check_vec("str_gap", 64'(tx_data2), 64'hBCBC);
        default: ;
      endcase
    end
    check_vec("str_rdy_cycles", 64'(rdy_cnt), 64'd3);
    check_vec("str_ur_pulses", 64'(ur_cnt), 64'd1);
    s_valid = 1'b0;

    // Link loss during payload word 1.
    hold_reset(COUNTER);
    for (int i = 1; i <= 9; i++) begin
      step();
      case (i)
        4: begin
          check_vec("lnk_w0", 64'(tx_data2), 64'h0100);
          link_ready = 1'b0;
        end
        5: begin
          check_vec("lnk_off_tx", 64'(tx_data2), 64'h0);
          check_vec("lnk_off_k", 64'(tx_k2), 64'h0);
          check_vec("lnk_off_rdy", 64'(s_ready2), 64'h0);
          check_vec("lnk_seq_kept", 64'(seq2), 64'd1);
        end
        6: begin
          check_vec("lnk_off_tx2", 64'(tx_data2), 64'h0);
          link_ready = 1'b1;
        end
        7: begin
          check_vec("lnk_gap0", 64'(tx_data2), 64'hBCBC);
          check_vec("lnk_gap0_k", 64'(tx_k2), 64'h3);
        end
        8: check_vec("lnk_gap1", 64'(tx_data2), 64'hBCBC);
        9: begin
          check_vec("lnk_sof", 64'(tx_data2), 64'h01FB);
          check_vec("lnk_seq", 64'(seq2), 64'd2);
        end
        default: ;
      endcase
    end

    // Mode change mid-payload applies to the next frame; PRBS from seed 7F.
    hold_reset(COUNTER);
    for (int i = 1; i <= 12; i++) begin
      step();
      case (i)
        4: begin
          check_vec("mch_w0", 64'(tx_data2), 64'h0100);
          mode = PRBS7;
        end
        5:  check_vec("mch_w1", 64'(tx_data2), 64'h0302);
        6:  check_vec("mch_w2", 64'(tx_data2), 64'h0504);
        7:  check_vec("mch_eof", 64'(tx_data2), 64'h01FD);
        10: check_vec("mch_sof", 64'(tx_data2), 64'h01FB);
        11: check_vec("mch_prbs0", 64'(tx_data2), 64'h3040);
        12: check_vec("mch_prbs1", 64'(tx_data2), 64'h4F14);
        default: ;
      endcase
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
